audio_mixer: RTL and testbench



---
 rtl/audio_mixer.sv | 92 +++++++++
 tb/tb_audio_mixer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/audio_mixer.sv
// audio_mixer: sequential multi-channel gain/mute mixer, one MAC per cycle,
// with saturating output, sticky clip flag and overrun detection.
module audio_mixer #(
    parameter int NUM_CH     = 4,
    parameter int IN_WIDTH   = 16,
    parameter int GAIN_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           sample_strobe_i,
    input  logic [NUM_CH*IN_WIDTH-1:0]     ch_data_i,
    input  logic [NUM_CH*GAIN_WIDTH-1:0]   gain_i,
    input  logic [NUM_CH-1:0]              mute_i,
    input  logic                           clip_clear_i,
    output logic [IN_WIDTH-1:0]            mix_o,
    output logic                           valid_o,
    output logic                           busy_o,
    output logic                           clip_o,
    output logic                           overrun_o
);
    localparam int ACC_W  = IN_WIDTH + GAIN_WIDTH + $clog2(NUM_CH) + 1;
    localparam int IDX_W  = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int PROD_W = IN_WIDTH + GAIN_WIDTH;

    typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

    state_t                  state, state_nxt;
    logic [IN_WIDTH-1:0]     ch_snap   [NUM_CH];
    logic [GAIN_WIDTH-1:0]   gain_snap [NUM_CH];
    logic [NUM_CH-1:0]       mute_snap;
    logic [ACC_W-1:0]        acc, res;
    logic [IDX_W-1:0]        idx;
    logic [PROD_W-1:0]       prod;
    logic                    last, sat, start;

    always_comb begin
        prod  = mute_snap[idx] ? '0 : PROD_W'(ch_snap[idx]) * PROD_W'(gain_snap[idx]);
        last  = idx == IDX_W'(NUM_CH - 1);
        res   = acc >> (GAIN_WIDTH - 1);
        sat   = |res[ACC_W-1:IN_WIDTH];
        start = state == IDLE && sample_strobe_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state == IDLE  ? (sample_strobe_i ? ACCUM : IDLE) :
                    state == ACCUM ? (last ? OUTPUT : ACCUM) : IDLE;
    end

    always_comb begin
        busy_o = state != IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < NUM_CH; n++) begin
                ch_snap[n]   <= '0;
                gain_snap[n] <= '0;
            end
            mute_snap <= '0;
            acc       <= '0;
            idx       <= '0;
            mix_o     <= '0;
            valid_o   <= 1'b0;
            clip_o    <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            valid_o   <= state == OUTPUT;
            overrun_o <= sample_strobe_i && state != IDLE;
            // Set has priority over clear when both land on the same edge.
            clip_o    <= (state == OUTPUT && sat) || (clip_o && !clip_clear_i);
            if (start) begin
                for (int n = 0; n < NUM_CH; n++) begin
                    ch_snap[n]   <= ch_data_i[n*IN_WIDTH +: IN_WIDTH];
                    gain_snap[n] <= gain_i[n*GAIN_WIDTH +: GAIN_WIDTH];
                end
                mute_snap <= mute_i;
                acc       <= '0;
                idx       <= '0;
            end
            if (state == ACCUM) begin
                acc <= acc + ACC_W'(prod);
                idx <= idx + IDX_W'(1);
            end
            if (state == OUTPUT) mix_o <= sat ? '1 : res[IN_WIDTH-1:0];
        end
    end
endmodule

// File: tb/tb_audio_mixer.sv
// tb_audio_mixer: directed-vector bench for audio_mixer (4 ch, 16-bit, 8-bit gain).
module tb_audio_mixer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_strobe_i = 1'b0;
    logic [63:0] ch_data_i = '0;
    logic [31:0] gain_i = '0;
    logic [3:0]  mute_i = '0;
    logic        clip_clear_i = 1'b0;
    logic [15:0] mix_o;
    logic        valid_o, busy_o, clip_o, overrun_o;

    int checks = 0;
    int errors = 0;

    audio_mixer #(.NUM_CH(4), .IN_WIDTH(16), .GAIN_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .sample_strobe_i(sample_strobe_i),
        .ch_data_i(ch_data_i), .gain_i(gain_i), .mute_i(mute_i),
        .clip_clear_i(clip_clear_i), .mix_o(mix_o), .valid_o(valid_o),
        .busy_o(busy_o), .clip_o(clip_o), .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Strobe is sampled at E0; inputs/outputs are driven/sampled 1 time unit after edges.
    task automatic run_mix(input logic [63:0] ch, input logic [31:0] g, input logic [3:0] m,
                           input logic clr, output logic [15:0] res, output int lat,
                           output int busy_n);
        @(negedge clk);
        ch_data_i = ch; gain_i = g; mute_i = m; sample_strobe_i = 1'b1;
        @(posedge clk);
        #1 sample_strobe_i = 1'b0;
        busy_n = int'(busy_o);
        lat = 0;
        res = '0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            if (clr && k == 5) clip_clear_i = 1'b1;
            @(posedge clk);
            #1 clip_clear_i = 1'b0;
            busy_n += int'(busy_o);
            if (valid_o) begin
                lat = k;
                res = mix_o;
            end
        end
    endtask

    logic [15:0] r;
    int lat, bn, nv, no;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_mix", 32'(mix_o), 0);
        check("rst_valid", 32'(valid_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_clip", 32'(clip_o), 0);
        check("rst_overrun", 32'(overrun_o), 0);
        @(negedge clk) reset = 1'b0;

        run_mix({4{16'h1000}}, {4{8'h80}}, 4'b0000, 1'b0, r, lat, bn);
        check("unity_mix", 32'(r), 32'h4000);
        check("unity_lat", 32'(lat), 5);
        check("unity_busy", 32'(bn), 5);
        check("unity_clip", 32'(clip_o), 0);
        check("unity_valid_pulse", 32'(valid_o), 1);
        @(posedge clk); #1;
        check("valid_one_cycle", 32'(valid_o), 0);
        check("mix_hold", 32'(mix_o), 32'h4000);

        run_mix({16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h1234}, {8'hFF, 8'hFF, 8'hFF, 8'h40},
                4'b1110, 1'b0, r, lat, bn);
        check("gain_mute_mix", 32'(r), 32'h091A);

        run_mix({48'h0, 16'h0002}, {24'h0, 8'hFF}, 4'b0000, 1'b0, r, lat, bn);
        check("trunc_mix", 32'(r), 32'h0003);

        run_mix({48'h0, 16'hFFFF}, {24'h0, 8'h80}, 4'b0000, 1'b0, r, lat, bn);
        check("fullscale_mix", 32'(r), 32'hFFFF);
        check("fullscale_noclip", 32'(clip_o), 0);

        run_mix({4{16'hFFFF}}, {4{8'h80}}, 4'b0000, 1'b0, r, lat, bn);
        check("sat_mix", 32'(r), 32'hFFFF);
        check("sat_clip", 32'(clip_o), 1);
        run_mix({4{16'h0000}}, {4{8'h80}}, 4'b0000, 1'b0, r, lat, bn);
        check("zero_mix", 32'(r), 0);
        check("clip_sticky", 32'(clip_o), 1);
        @(negedge clk) clip_clear_i = 1'b1;
        @(posedge clk); #1 clip_clear_i = 1'b0;
        check("clip_cleared", 32'(clip_o), 0);

        run_mix({48'h0, 16'hFFFF}, {24'h0, 8'h81}, 4'b0000, 1'b0, r, lat, bn);
        check("just_over_mix", 32'(r), 32'hFFFF);
        check("just_over_clip", 32'(clip_o), 1);
        @(negedge clk) clip_clear_i = 1'b1;
        @(posedge clk); #1 clip_clear_i = 1'b0;

        // Overrun: strobe at E0, inputs changed after E1, second strobe at E2.
        @(negedge clk);
        ch_data_i = {4{16'h1000}}; gain_i = {4{8'h80}}; mute_i = '0; sample_strobe_i = 1'b1;
        @(posedge clk); #1 sample_strobe_i = 1'b0;
        @(posedge clk); #1 ch_data_i = {4{16'h2000}}; sample_strobe_i = 1'b1;
        @(posedge clk); #1 sample_strobe_i = 1'b0;
        no = int'(overrun_o);
        check("overrun_pulse", 32'(overrun_o), 1);
        nv = 0; r = '0;
        for (int k = 3; k <= 12; k++) begin
            @(posedge clk); #1;
            no += int'(overrun_o);
            nv += int'(valid_o);
            if (valid_o) r = mix_o;
        end
        check("overrun_count", 32'(no), 1);
        check("overrun_valid_count", 32'(nv), 1);
        check("snapshot_mix", 32'(r), 32'h4000);

        // Back-to-back: strobe arriving the cycle after OUTPUT is accepted.
        run_mix({4{16'h0800}}, {4{8'h80}}, 4'b0000, 1'b0, r, lat, bn);
        run_mix({4{16'h0400}}, {4{8'h80}}, 4'b0000, 1'b0, r, lat, bn);
        check("b2b_mix", 32'(r), 32'h1000);
        check("b2b_lat", 32'(lat), 5);

        // Reset asserted at E3 of a mix.
        @(negedge clk);
        ch_data_i = {4{16'h0100}}; sample_strobe_i = 1'b1;
        @(posedge clk); #1 sample_strobe_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrst_mix", 32'(mix_o), 0);
        check("midrst_busy", 32'(busy_o), 0);
        check("midrst_valid", 32'(valid_o), 0);
        @(posedge clk);
        @(negedge clk) reset = 1'b0;
        nv = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            nv += int'(valid_o);
        end
        check("midrst_no_valid", 32'(nv), 0);
        run_mix({4{16'h1000}}, {4{8'h80}}, 4'b0000, 1'b0, r, lat, bn);
        check("postrst_mix", 32'(r), 32'h4000);
        check("postrst_lat", 32'(lat), 5);

        // Clear coincident with a saturating OUTPUT: set wins.
        run_mix({4{16'hFFFF}}, {4{8'h80}}, 4'b0000, 1'b1, r, lat, bn);
        check("collision_clip", 32'(clip_o), 1);
        check("collision_mix", 32'(r), 32'hFFFF);

        // Clear coincident with a non-saturating OUTPUT: clear takes effect.
        run_mix({4{16'h0010}}, {4{8'h80}}, 4'b0000, 1'b1, r, lat, bn);
        check("nosat_clear_clip", 32'(clip_o), 0);
        check("nosat_clear_mix", 32'(r), 32'h0040);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
